// File: rtl/sram_stack_ctrl.sv
// LIFO stack kept in a single-port SRAM. After reset it zero-fills the SRAM, then serves one push or pop per cycle.
// Latency: pop data arrives one cycle after the grant. Backpressure: push is held off when full, pop when empty, and both during init and flush.
module sram_stack_ctrl #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  input  logic          pop_valid,
  output logic          pop_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          busy,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);

  localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] SP_ONE = (AW+1)'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] init_cnt, init_cnt_nxt;
  logic [AW:0]   sp, sp_nxt;
  logic          last_push, last_push_nxt;
  logic          rd_vld_q;
  logic          push_elig, pop_elig, grant_push, grant_pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= INIT;
      init_cnt  <= '0;
      sp        <= '0;
      last_push <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      sp        <= sp_nxt;
      last_push <= last_push_nxt;
      rd_vld_q  <= grant_pop;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    sp_nxt        = sp;
    last_push_nxt = last_push;
    push_elig     = 1'b0;
    pop_elig      = 1'b0;
    grant_push    = 1'b0;
    grant_pop     = 1'b0;
    busy          = 1'b1;
    CEN           = 1'b1;
    WEN           = 1'b1;
    A             = '0;
    D             = '0;
    // Outputs stay idle while reset is held, even though the state reads INIT.
    if (RST_N) begin
      case (state)
        INIT: begin
          CEN          = 1'b0;
          WEN          = 1'b0;
          A            = init_cnt;
          init_cnt_nxt = init_cnt + AW'(1);
          if (&init_cnt) state_nxt = RUN;
        end
        RUN: begin
          busy = 1'b0;
          if (flush) begin
            sp_nxt = '0;
          end else begin
            push_elig  = push_valid && (sp != DEPTH);
            pop_elig   = pop_valid && (sp != '0);
            // When both contend, the type that lost last time wins.
            grant_push = push_elig && (!pop_elig || !last_push);
            grant_pop  = pop_elig && !grant_push;
            if (grant_push) begin
              CEN           = 1'b0;
              WEN           = 1'b0;
              A             = sp[AW-1:0];
              D             = push_data;
              sp_nxt        = sp + SP_ONE;
              last_push_nxt = 1'b1;
            end else if (grant_pop) begin
              CEN           = 1'b0;
              A             = sp[AW-1:0] - AW'(1);
              sp_nxt        = sp - SP_ONE;
              last_push_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  assign push_ready = grant_push;
  assign pop_ready  = grant_pop;
  assign rd_valid   = rd_vld_q;
  assign rd_data    = rd_vld_q ? Q : '0;
  assign level      = sp;
  assign empty      = (sp == '0);
  assign full       = (sp == DEPTH);

endmodule

// File: tb/tb_sram_stack_ctrl.sv
// Bench for sram_stack_ctrl: behavioural stack model checked every cycle plus directed scenarios.
module tb_sram_stack_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N, flush, push_valid, pop_valid;
  logic [7:0] push_data;
  logic       push_ready, pop_ready, rd_valid;
  logic [7:0] rd_data;
  logic [8:0] level;
  logic       empty, full, busy, CEN, WEN;
  logic [7:0] A, D;
  logic [7:0] Q = 8'h00;
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  bit m_init = 1'b1;
  int m_cnt = 0;
  int m_sp = 0;
  bit m_last_push = 1'b0;
  bit m_rd_pend = 1'b0;
  int m_rd_exp = 0;
  int m_stack [256];
  int popped [$];

  always #5 CLK = ~CLK;

  sram_stack_ctrl #(.DW(8), .AW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .empty(empty), .full(full), .busy(busy),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  // Single-port synchronous SRAM.
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= mem[A];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {push granted, pop granted} according to the stack rules.
  function automatic logic [1:0] model_grant();
    bit pe, oe, gp;
    pe = push_valid && !flush && (m_sp < 256);
    oe = pop_valid && !flush && (m_sp > 0);
    gp = pe && (!oe || !m_last_push);
    return {gp, oe && !gp};
  endfunction

  // Model update at each edge, or immediately on reset assertion.
  initial forever begin
    logic [1:0] g;
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_init = 1'b1; m_cnt = 0; m_sp = 0; m_last_push = 1'b0; m_rd_pend = 1'b0;
    end else if (m_init) begin
      m_rd_pend = 1'b0;
      m_cnt++;
      if (m_cnt == 256) begin
        m_init = 1'b0;
        m_cnt = 0;
      end
    end else begin
      g = model_grant();
      m_rd_pend = g[0];
      if (flush) begin
        m_sp = 0;
      end else if (g[1]) begin
        m_stack[m_sp] = int'(push_data);
        m_sp++;
        m_last_push = 1'b1;
      end else if (g[0]) begin
        m_rd_exp = m_stack[m_sp-1];
        m_sp--;
        m_last_push = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    logic [1:0] g;
    @(negedge CLK);
    if (!RST_N) begin
      chk("rst_busy", busy, 1); chk("rst_push_ready", push_ready, 0);
      chk("rst_pop_ready", pop_ready, 0); chk("rst_cen", CEN, 1);
      chk("rst_wen", WEN, 1); chk("rst_a", A, 0); chk("rst_d", D, 0);
      chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
      chk("rst_level", level, 0);
    end else if (m_init) begin
      chk("init_busy", busy, 1); chk("init_push_ready", push_ready, 0);
      chk("init_pop_ready", pop_ready, 0); chk("init_cen", CEN, 0);
      chk("init_wen", WEN, 0); chk("init_a", A, m_cnt); chk("init_d", D, 0);
      chk("init_rd_valid", rd_valid, 0);
    end else begin
      g = model_grant();
      chk("push_ready", push_ready, g[1]); chk("pop_ready", pop_ready, g[0]);
      chk("busy", busy, 0); chk("level", level, m_sp);
      chk("empty", empty, m_sp == 0); chk("full", full, m_sp == 256);
      if (g[1]) begin
        chk("push_cen", CEN, 0); chk("push_wen", WEN, 0);
        chk("push_a", A, m_sp); chk("push_d", D, push_data);
      end else if (g[0]) begin
        chk("pop_cen", CEN, 0); chk("pop_wen", WEN, 1); chk("pop_a", A, m_sp - 1);
      end else begin
        chk("idle_cen", CEN, 1); chk("idle_wen", WEN, 1);
        chk("idle_a", A, 0); chk("idle_d", D, 0);
      end
      chk("rd_valid", rd_valid, m_rd_pend);
      chk("rd_data", rd_data, m_rd_pend ? m_rd_exp : 0);
      if (rd_valid) popped.push_back(int'(rd_data));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic init_check();
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      chk("seq_init_busy", busy, 1);
      chk("seq_init_addr", A, i);
    end
    @(negedge CLK);
    chk("seq_run_busy", busy, 0);
    chk("seq_run_empty", empty, 1);
    chk("seq_run_level", level, 0);
  endtask

  initial begin
    RST_N = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; push_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    init_check();

    // LIFO ordering
    tick();
    popped.delete();
    push_valid = 1'b1;
    push_data = 8'h11; tick();
    push_data = 8'h22; tick();
    push_data = 8'h33; tick();
    push_valid = 1'b0; pop_valid = 1'b1;
    repeat (3) tick();
    pop_valid = 1'b0;
    tick();
    @(negedge CLK);
    chk("lifo_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("lifo_pop0", popped[0], 8'h33);
      chk("lifo_pop1", popped[1], 8'h22);
      chk("lifo_pop2", popped[2], 8'h11);
    end
    chk("lifo_level", level, 0);

    // Fill to full, then drain and try popping empty
    tick();
    popped.delete();
    push_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_data = 8'(i);
      tick();
    end
    @(negedge CLK);
    chk("full_flag", full, 1); chk("full_level", level, 256); chk("full_push_ready", push_ready, 0);
    tick();
    @(negedge CLK);
    chk("full_level_held", level, 256);
    push_valid = 1'b0; pop_valid = 1'b1;
    tick();
    repeat (255) tick();
    @(negedge CLK);
    chk("empty_flag", empty, 1); chk("empty_pop_ready", pop_ready, 0);
    tick();
    @(negedge CLK);
    chk("empty_no_rd_valid", rd_valid, 0);
    pop_valid = 1'b0;
    chk("drain_count", popped.size(), 256);
    if (popped.size() == 256) begin
      chk("drain_first", popped[0], 255);
      chk("drain_last", popped[255], 0);
    end

    // Round-robin arbitration at level 4, last grant a pop
    tick();
    push_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_data = 8'(i);
      tick();
    end
    push_valid = 1'b0; pop_valid = 1'b1;
    tick();
    push_valid = 1'b1; push_data = 8'hA0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("arb_push_ready", push_ready, (k % 2) == 0);
      chk("arb_pop_ready", pop_ready, (k % 2) == 1);
      chk("arb_level", level, ((k % 2) == 0) ? 4 : 5);
      tick();
    end
    push_valid = 1'b0; pop_valid = 1'b0;

    // Flush at level 10 with a push pending
    push_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_data = 8'(8'h40 + i);
      tick();
    end
    flush = 1'b1; push_data = 8'hEE;
    @(negedge CLK);
    chk("flush_level_before", level, 10);
    chk("flush_push_ready", push_ready, 0);
    chk("flush_cen", CEN, 1);
    tick();
    flush = 1'b0; push_valid = 1'b0;
    @(negedge CLK);
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    popped.delete();
    tick();
    push_valid = 1'b1; push_data = 8'h5A;
    tick();
    push_valid = 1'b0; pop_valid = 1'b1;
    tick();
    pop_valid = 1'b0;
    tick();
    @(negedge CLK);
    chk("flush_after_count", popped.size(), 1);
    if (popped.size() == 1) chk("flush_after_data", popped[0], 8'h5A);

    // Reset between a pop grant and its data cycle
    tick();
    push_valid = 1'b1; push_data = 8'h77;
    tick();
    push_valid = 1'b0; pop_valid = 1'b1;
    @(negedge CLK);
    chk("rstpop_pop_ready", pop_ready, 1);
    #1 RST_N = 1'b0; pop_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rstpop_rd_valid", rd_valid, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    init_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
